// File: rtl/pwm_capture_pkg.sv
// pwm_capture_pkg: register map, bit positions and FSM encoding shared by the capture block.
package pwm_capture_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_HIGH   = 2'd2;
    localparam logic [1:0] ADDR_PERIOD = 2'd3;

    localparam int CTRL_ENABLE     = 0;
    localparam int CTRL_CLEAR      = 1;

    localparam int STATUS_VALID    = 0;
    localparam int STATUS_OVERFLOW = 1;
    localparam int STATUS_LEVEL    = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2
    } captureState_t;

endpackage

// File: rtl/pwm_capture_edge_sync.sv
// pwm_edge_sync: brings the asynchronous PWM input into the iClk domain and flags its edges.
module pwm_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic iClk,
    input  logic iReset_n,
    input  logic pwm,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] syncChain;
    logic                   levelDly;

    // Synchronizer chain plus one extra flop so edges can be detected on the clean level.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            syncChain <= '0;
            levelDly  <= 1'b0;
        end else begin
            syncChain <= {syncChain[SYNC_STAGES-2:0], pwm};
            levelDly  <= syncChain[SYNC_STAGES-1];
        end
    end

    assign level = syncChain[SYNC_STAGES-1];
    assign rise  = level & ~levelDly;
    assign fall  = ~level & levelDly;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of a PWM input in iClk cycles, bus-readable results.
//
//  state | meaning
//  IDLE  | disabled; counters held at zero, last results kept
//  ARM   | enabled, waiting for the first rising edge to start a measurement
//  MEAS  | counting; each rising edge latches PERIOD/HIGH and restarts the count
module pwm_capture #(
    parameter int CNT_W       = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic        iClk,
    input  logic        iReset_n,
    input  logic        iChipselect_n,
    input  logic        iWrite_n,
    input  logic        iRead_n,
    input  logic [1:0]  iAddress,
    input  logic [31:0] iData,
    output logic [31:0] oData,
    input  logic        iPwm
);
    import pwm_capture_pkg::*;

    logic             s;
    logic             rise;
    logic             fall;
    logic             enable;
    logic             valid;
    logic             overflow;
    logic [CNT_W-1:0] pcnt;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] highReg;
    logic [CNT_W-1:0] periodReg;
    captureState_t    state;

    logic             busWrite;
    logic             busRead;
    logic             ctrlWrite;
    logic             clearReq;
    logic [31:0]      readMux;
    logic             unusedBits;

    pwm_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) uEdgeSync (
        .iClk     (iClk),
        .iReset_n (iReset_n),
        .pwm      (iPwm),
        .level    (s),
        .rise     (rise),
        .fall     (fall)
    );

    // A simultaneous write and read strobe is treated as a write only.
    assign busWrite  = !iChipselect_n && !iWrite_n;
    assign busRead   = !iChipselect_n && iWrite_n && !iRead_n;
    assign ctrlWrite = busWrite && (iAddress == ADDR_CTRL);
    assign clearReq  = ctrlWrite && iData[CTRL_CLEAR];

    // Only the two CTRL bits of the write data are meaningful; the falling edge is not needed here.
    assign unusedBits = ^{iData[31:2], fall};

    // Read data selection, zero-extended to the bus width.
    always_comb begin
        readMux = '0;
        case (iAddress)
            ADDR_CTRL:   readMux[CTRL_ENABLE] = enable;
            ADDR_STATUS: begin
                readMux[STATUS_VALID]    = valid;
                readMux[STATUS_OVERFLOW] = overflow;
                readMux[STATUS_LEVEL]    = s;
            end
            ADDR_HIGH:   readMux[CNT_W-1:0] = highReg;
            ADDR_PERIOD: readMux[CNT_W-1:0] = periodReg;
            default:     readMux = '0;
        endcase
    end

    // Registered read port: updates only on a read strobe, otherwise holds.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            oData <= '0;
        end else if (busRead) begin
            oData <= readMux;
        end
    end

    // Control register, measurement FSM, counters and result registers.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            enable    <= 1'b0;
            valid     <= 1'b0;
            overflow  <= 1'b0;
            pcnt      <= '0;
            hcnt      <= '0;
            highReg   <= '0;
            periodReg <= '0;
            state     <= IDLE;
        end else begin
            if (ctrlWrite) begin
                enable <= iData[CTRL_ENABLE];
            end
            // Read-clear first so a latch in the same cycle can set valid again.
            if (busRead && (iAddress == ADDR_PERIOD)) begin
                valid <= 1'b0;
            end
            if (clearReq) begin
                highReg   <= '0;
                periodReg <= '0;
                valid     <= 1'b0;
                overflow  <= 1'b0;
                pcnt      <= '0;
                hcnt      <= '0;
                state     <= iData[CTRL_ENABLE] ? ARM : IDLE;
            end else if (!enable) begin
                pcnt  <= '0;
                hcnt  <= '0;
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: state <= ARM;
                    ARM: begin
                        if (rise) begin
                            pcnt  <= CNT_W'(1);
                            hcnt  <= CNT_W'(1);
                            state <= MEAS;
                        end
                    end
                    MEAS: begin
                        if (rise) begin
                            periodReg <= pcnt;
                            highReg   <= hcnt;
                            valid     <= 1'b1;
                            pcnt      <= CNT_W'(1);
                            hcnt      <= CNT_W'(1);
                        end else if (&pcnt) begin
                            // Period too long to represent: flag it and wait for a fresh edge.
                            overflow <= 1'b1;
                            pcnt     <= '0;
                            hcnt     <= '0;
                            state    <= ARM;
                        end else begin
                            pcnt <= pcnt + CNT_W'(1);
                            hcnt <= hcnt + CNT_W'(s);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: drives an ideal PWM source into a 24-bit and an 8-bit capture instance.
module tb_pwm_capture;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_HIGH   = 2'd2;
    localparam logic [1:0] A_PERIOD = 2'd3;

    logic        clk = 1'b0;
    logic        rstN;
    logic        csN, wrN, rdN;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] oData24, oData8;
    logic        pwm;

    int nCompared   = 0;
    int nMismatched = 0;

    // Ideal PWM source: period/high take effect at the start of a period.
    int curPer   = 10;
    int curHigh  = 3;
    int nextPer  = 10;
    int nextHigh = 3;
    int phase    = 0;
    bit pwmRun   = 1'b0;
    bit pwmLevel = 1'b0;

    logic [31:0] r24, r8;

    always #5 clk = ~clk;

    pwm_capture #(.CNT_W(24), .SYNC_STAGES(2)) dut24 (
        .iClk(clk), .iReset_n(rstN), .iChipselect_n(csN), .iWrite_n(wrN), .iRead_n(rdN),
        .iAddress(addr), .iData(wdata), .oData(oData24), .iPwm(pwm)
    );

    pwm_capture #(.CNT_W(8), .SYNC_STAGES(2)) dut8 (
        .iClk(clk), .iReset_n(rstN), .iChipselect_n(csN), .iWrite_n(wrN), .iRead_n(rdN),
        .iAddress(addr), .iData(wdata), .oData(oData8), .iPwm(pwm)
    );

    initial begin
        pwm = 1'b0;
        forever begin
            @(negedge clk);
            if (!pwmRun) begin
                pwm     = pwmLevel;
                phase   = 0;
                curPer  = nextPer;
                curHigh = nextHigh;
            end else begin
                if (phase == 0) begin
                    curPer  = nextPer;
                    curHigh = nextHigh;
                end
                pwm   = (phase < curHigh);
                phase = (phase + 1 >= curPer) ? 0 : phase + 1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic busWrite(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        csN = 1'b0; wrN = 1'b0; addr = a; wdata = d;
        @(negedge clk);
        csN = 1'b1; wrN = 1'b1;
    endtask

    task automatic busRead(input logic [1:0] a, output logic [31:0] d24, output logic [31:0] d8);
        @(negedge clk);
        csN = 1'b0; rdN = 1'b0; addr = a;
        @(negedge clk);
        d24 = oData24; d8 = oData8;
        csN = 1'b1; rdN = 1'b1;
    endtask

    task automatic setPwm(input int p, input int h);
        @(posedge clk);
        nextPer = p; nextHigh = h; pwmRun = 1'b1;
    endtask

    task automatic waitSettled(input int rises);
        repeat (rises) @(posedge pwm);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        nCompared++; if (oData24 !== 32'd0) begin nMismatched++; $display("FAIL rst_odata24: got %0h want 0", oData24); end
        nCompared++; if (oData8 !== 32'd0) begin nMismatched++; $display("FAIL rst_odata8: got %0h want 0", oData8); end
        @(negedge clk); rstN = 1'b1;
        for (int a = 0; a < 4; a++) begin
            busRead(2'(a), r24, r8);
            nCompared++; if (r24 !== 32'd0) begin nMismatched++; $display("FAIL rst_reg24[%0d]: got %0h want 0", a, r24); end
            nCompared++; if (r8 !== 32'd0) begin nMismatched++; $display("FAIL rst_reg8[%0d]: got %0h want 0", a, r8); end
        end
    endtask

    task automatic test_bus();
        busWrite(A_CTRL, 32'h0000_0003);
        busRead(A_CTRL, r24, r8);
        nCompared++; if (r24 !== 32'd1) begin nMismatched++; $display("FAIL ctrl_rd24: got %0h want 1", r24); end
        nCompared++; if (r8 !== 32'd1) begin nMismatched++; $display("FAIL ctrl_rd8: got %0h want 1", r8); end
        for (int a = 1; a < 4; a++) busWrite(2'(a), 32'hFFFF_FFFF);
        for (int a = 1; a < 4; a++) begin
            busRead(2'(a), r24, r8);
            nCompared++; if (r24 !== 32'd0) begin nMismatched++; $display("FAIL ro_write24[%0d]: got %0h want 0", a, r24); end
            nCompared++; if (r8 !== 32'd0) begin nMismatched++; $display("FAIL ro_write8[%0d]: got %0h want 0", a, r8); end
        end
        busRead(A_CTRL, r24, r8);
        // Deselected read: oData must hold the CTRL value just read.
        @(negedge clk); csN = 1'b1; rdN = 1'b0; addr = A_STATUS;
        @(negedge clk); rdN = 1'b1;
        nCompared++; if (oData24 !== 32'd1) begin nMismatched++; $display("FAIL cs_hold24: got %0h want 1", oData24); end
        // Write and read together at STATUS: the write wins and is ignored, oData holds.
        @(negedge clk); csN = 1'b0; wrN = 1'b0; rdN = 1'b0; addr = A_STATUS; wdata = 32'h0;
        @(negedge clk); csN = 1'b1; wrN = 1'b1; rdN = 1'b1;
        nCompared++; if (oData8 !== 32'd1) begin nMismatched++; $display("FAIL wr_rd_hold8: got %0h want 1", oData8); end
        busWrite(A_CTRL, 32'h0);
        busRead(A_CTRL, r24, r8);
        nCompared++; if (r24 !== 32'd0) begin nMismatched++; $display("FAIL ctrl_off24: got %0h want 0", r24); end
    endtask

    task automatic test_measure();
        busWrite(A_CTRL, 32'h1);
        setPwm(10, 3);
        waitSettled(3);
        busRead(A_STATUS, r24, r8);
        nCompared++; if (r24[1:0] !== 2'b01) begin nMismatched++; $display("FAIL meas_status24: got %0b want 01", r24[1:0]); end
        nCompared++; if (r8[1:0] !== 2'b01) begin nMismatched++; $display("FAIL meas_status8: got %0b want 01", r8[1:0]); end
        busRead(A_HIGH, r24, r8);
        nCompared++; if (r24 !== 32'd3) begin nMismatched++; $display("FAIL meas_high24: got %0d want 3", r24); end
        nCompared++; if (r8 !== 32'd3) begin nMismatched++; $display("FAIL meas_high8: got %0d want 3", r8); end
        busRead(A_PERIOD, r24, r8);
        nCompared++; if (r24 !== 32'd10) begin nMismatched++; $display("FAIL meas_period24: got %0d want 10", r24); end
        nCompared++; if (r8 !== 32'd10) begin nMismatched++; $display("FAIL meas_period8: got %0d want 10", r8); end
    endtask

    task automatic test_read_clear();
        @(posedge pwm); repeat (2) @(negedge clk);
        busRead(A_PERIOD, r24, r8);
        nCompared++; if (r24 !== 32'd10) begin nMismatched++; $display("FAIL rc_period24: got %0d want 10", r24); end
        busRead(A_STATUS, r24, r8);
        nCompared++; if (r24[0] !== 1'b0) begin nMismatched++; $display("FAIL rc_valid24: got %0b want 0", r24[0]); end
        nCompared++; if (r8[0] !== 1'b0) begin nMismatched++; $display("FAIL rc_valid8: got %0b want 0", r8[0]); end
        setPwm(13, 3);
        do @(posedge pwm); while (curPer != 13);
        @(posedge pwm);
        @(negedge clk);
        // This read strobe lands on the edge that latches the first 13-cycle period.
        busRead(A_PERIOD, r24, r8);
        nCompared++; if (r24 !== 32'd10) begin nMismatched++; $display("FAIL align_old24: got %0d want 10", r24); end
        nCompared++; if (r8 !== 32'd10) begin nMismatched++; $display("FAIL align_old8: got %0d want 10", r8); end
        busRead(A_STATUS, r24, r8);
        nCompared++; if (r24[0] !== 1'b1) begin nMismatched++; $display("FAIL align_valid24: got %0b want 1", r24[0]); end
        busRead(A_PERIOD, r24, r8);
        nCompared++; if (r8 !== 32'd13) begin nMismatched++; $display("FAIL align_new8: got %0d want 13", r8); end
        busRead(A_HIGH, r24, r8);
        nCompared++; if (r24 !== 32'd3) begin nMismatched++; $display("FAIL align_high24: got %0d want 3", r24); end
    endtask

    task automatic test_overflow();
        @(posedge clk); pwmRun = 1'b0; pwmLevel = 1'b0;
        repeat (6) @(negedge clk);
        busWrite(A_CTRL, 32'h3);
        busRead(A_STATUS, r24, r8);
        nCompared++; if (r8[1:0] !== 2'b00) begin nMismatched++; $display("FAIL ovf_pre8: got %0b want 00", r8[1:0]); end
        @(posedge clk); pwmLevel = 1'b1;
        @(posedge pwm);
        repeat (2) @(negedge clk);
        @(posedge clk); pwmLevel = 1'b0;
        repeat (237) @(negedge clk);
        busRead(A_STATUS, r24, r8);
        nCompared++; if (r8[2:0] !== 3'b000) begin nMismatched++; $display("FAIL ovf_early8: got %0b want 000", r8[2:0]); end
        repeat (28) @(negedge clk);
        busRead(A_STATUS, r24, r8);
        nCompared++; if (r8[2:0] !== 3'b010) begin nMismatched++; $display("FAIL ovf_set8: got %0b want 010", r8[2:0]); end
        nCompared++; if (r24[2:0] !== 3'b000) begin nMismatched++; $display("FAIL ovf_none24: got %0b want 000", r24[2:0]); end
        setPwm(20, 5);
        waitSettled(4);
        busRead(A_STATUS, r24, r8);
        nCompared++; if (r8[1:0] !== 2'b11) begin nMismatched++; $display("FAIL ovf_sticky8: got %0b want 11", r8[1:0]); end
        nCompared++; if (r24[1:0] !== 2'b01) begin nMismatched++; $display("FAIL ovf_status24: got %0b want 01", r24[1:0]); end
        busRead(A_HIGH, r24, r8);
        nCompared++; if (r8 !== 32'd5) begin nMismatched++; $display("FAIL ovf_high8: got %0d want 5", r8); end
        busRead(A_PERIOD, r24, r8);
        nCompared++; if (r8 !== 32'd20) begin nMismatched++; $display("FAIL ovf_period8: got %0d want 20", r8); end
        nCompared++; if (r24 !== 32'd20) begin nMismatched++; $display("FAIL ovf_period24: got %0d want 20", r24); end
    endtask

    task automatic test_clear();
        busWrite(A_CTRL, 32'h3);
        busRead(A_STATUS, r24, r8);
        nCompared++; if (r8[1:0] !== 2'b00) begin nMismatched++; $display("FAIL clr_status8: got %0b want 00", r8[1:0]); end
        nCompared++; if (r24[1:0] !== 2'b00) begin nMismatched++; $display("FAIL clr_status24: got %0b want 00", r24[1:0]); end
        busRead(A_HIGH, r24, r8);
        nCompared++; if (r24 !== 32'd0) begin nMismatched++; $display("FAIL clr_high24: got %0d want 0", r24); end
        busRead(A_PERIOD, r24, r8);
        nCompared++; if (r8 !== 32'd0) begin nMismatched++; $display("FAIL clr_period8: got %0d want 0", r8); end
        busWrite(A_CTRL, 32'h0);
        waitSettled(4);
        busRead(A_STATUS, r24, r8);
        nCompared++; if (r24[1:0] !== 2'b00) begin nMismatched++; $display("FAIL idle_status24: got %0b want 00", r24[1:0]); end
        busRead(A_PERIOD, r24, r8);
        nCompared++; if (r24 !== 32'd0) begin nMismatched++; $display("FAIL idle_period24: got %0d want 0", r24); end
        nCompared++; if (r8 !== 32'd0) begin nMismatched++; $display("FAIL idle_period8: got %0d want 0", r8); end
        busWrite(A_CTRL, 32'h1);
        waitSettled(4);
        busRead(A_STATUS, r24, r8);
        nCompared++; if (r24[1:0] !== 2'b01) begin nMismatched++; $display("FAIL reen_status24: got %0b want 01", r24[1:0]); end
        // Clear strobe on the same edge as a latching rise: nothing may be latched.
        @(posedge pwm); @(negedge clk);
        busWrite(A_CTRL, 32'h3);
        busRead(A_STATUS, r24, r8);
        nCompared++; if (r24[1:0] !== 2'b00) begin nMismatched++; $display("FAIL clr_rise_status24: got %0b want 00", r24[1:0]); end
        nCompared++; if (r8[1:0] !== 2'b00) begin nMismatched++; $display("FAIL clr_rise_status8: got %0b want 00", r8[1:0]); end
        busRead(A_PERIOD, r24, r8);
        nCompared++; if (r24 !== 32'd0) begin nMismatched++; $display("FAIL clr_rise_period24: got %0d want 0", r24); end
        waitSettled(4);
        busRead(A_PERIOD, r24, r8);
        nCompared++; if (r8 !== 32'd20) begin nMismatched++; $display("FAIL clr_arm_period8: got %0d want 20", r8); end
    endtask

    task automatic test_random();
        int p, h;
        for (int i = 0; i < 6; i++) begin
            p = $urandom_range(200, 2);
            if (i == 0) p = 2;
            h = $urandom_range(p - 1, 1);
            if (i == 1) h = 1;
            if (i == 2) h = p - 1;
            setPwm(p, h);
            waitSettled(4);
            busRead(A_STATUS, r24, r8);
            nCompared++; if (r24[1:0] !== 2'b01) begin nMismatched++; $display("FAIL rnd_status24 p=%0d h=%0d: got %0b want 01", p, h, r24[1:0]); end
            nCompared++; if (r8[1:0] !== 2'b01) begin nMismatched++; $display("FAIL rnd_status8 p=%0d h=%0d: got %0b want 01", p, h, r8[1:0]); end
            busRead(A_HIGH, r24, r8);
            nCompared++; if (r24 !== 32'(h)) begin nMismatched++; $display("FAIL rnd_high24 p=%0d: got %0d want %0d", p, r24, h); end
            nCompared++; if (r8 !== 32'(h)) begin nMismatched++; $display("FAIL rnd_high8 p=%0d: got %0d want %0d", p, r8, h); end
            busRead(A_PERIOD, r24, r8);
            nCompared++; if (r24 !== 32'(p)) begin nMismatched++; $display("FAIL rnd_period24 h=%0d: got %0d want %0d", h, r24, p); end
            nCompared++; if (r8 !== 32'(p)) begin nMismatched++; $display("FAIL rnd_period8 h=%0d: got %0d want %0d", h, r8, p); end
        end
    endtask

    task automatic test_reset_midrun();
        setPwm(37, 11);
        waitSettled(4);
        busRead(A_PERIOD, r24, r8);
        nCompared++; if (r24 !== 32'd37) begin nMismatched++; $display("FAIL pre_rst_period24: got %0d want 37", r24); end
        @(negedge clk); #2;
        rstN = 1'b0;
        #1;
        nCompared++; if (oData24 !== 32'd0) begin nMismatched++; $display("FAIL async_rst24: got %0h want 0", oData24); end
        nCompared++; if (oData8 !== 32'd0) begin nMismatched++; $display("FAIL async_rst8: got %0h want 0", oData8); end
        @(posedge clk); pwmRun = 1'b0; pwmLevel = 1'b0;
        repeat (4) @(negedge clk);
        rstN = 1'b1;
        for (int a = 0; a < 4; a++) begin
            busRead(2'(a), r24, r8);
            nCompared++; if (r24 !== 32'd0) begin nMismatched++; $display("FAIL post_rst24[%0d]: got %0h want 0", a, r24); end
            nCompared++; if (r8 !== 32'd0) begin nMismatched++; $display("FAIL post_rst8[%0d]: got %0h want 0", a, r8); end
        end
    endtask

    initial begin
        rstN = 1'b0; csN = 1'b1; wrN = 1'b1; rdN = 1'b1; addr = 2'd0; wdata = 32'd0;
        repeat (3) @(negedge clk);
        test_reset();
        test_bus();
        test_measure();
        test_read_clear();
        test_overflow();
        test_clear();
        test_random();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
